// File: rtl/dataslot_save_writer.sv
// dataslot_save_writer: stages core save data into a local buffer, then asks
// the host (core_dataslot_write) to copy that region into a dataslot file.
// While the command is outstanding the buffer is frozen and bridge reads of
// the staged region are answered from it.
module dataslot_save_writer #(
  parameter logic [31:0] BRIDGE_BASE    = 32'h1000_0000,
  parameter int          DEPTH_WORDS    = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_000_000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           buf_wr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] buf_addr,
  input  logic [31:0]                    buf_data,
  output logic                           buf_wr_dropped,
  input  logic                           save_req,
  input  logic [15:0]                    save_slot_id,
  input  logic [31:0]                    save_offset,
  input  logic [31:0]                    save_length,
  output logic                           busy,
  output logic                           save_done,
  output logic                           save_error,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [15:0]                    cmd_slot_id,
  output logic [31:0]                    cmd_offset,
  output logic [31:0]                    cmd_bridge_addr,
  output logic [31:0]                    cmd_length,
  input  logic                           cmd_done,
  input  logic [15:0]                    cmd_status,
  input  logic                           bridge_rd,
  input  logic [31:0]                    bridge_addr,
  output logic [31:0]                    bridge_rd_data
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BUF_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] slot_q, slot_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] length_q, length_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rd_data_q;
  logic [31:0] mem [DEPTH_WORDS];

  // Byte offset of the bridge access inside the buffer window; addresses
  // below the base wrap to huge values and fall out of range naturally.
  logic [31:0]   rd_off;
  logic          rd_hit;
  logic [AW-1:0] rd_idx;

  assign rd_off = bridge_addr - BRIDGE_BASE;
  assign rd_hit = (rd_off < BUF_BYTES);
  assign rd_idx = rd_off[AW+1:2];

  assign busy            = (state_q != ST_IDLE);
  assign cmd_valid       = (state_q == ST_REQ);
  assign cmd_slot_id     = slot_q;
  assign cmd_offset      = offset_q;
  assign cmd_length      = length_q;
  assign cmd_bridge_addr = BRIDGE_BASE;
  assign save_done       = done_q;
  assign save_error      = err_q;
  assign bridge_rd_data  = rd_data_q;
  assign buf_wr_dropped  = buf_wr && (state_q != ST_IDLE);

  // Next-state, parameter latch, timeout counting and completion pulses.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    offset_d  = offset_q;
    length_d  = length_q;
    tmo_cnt_d = tmo_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (save_req) begin
          slot_d   = save_slot_id;
          offset_d = save_offset;
          length_d = save_length;
          if (save_length == 32'd0) begin
            done_d = 1'b1;
          end else if (save_length > BUF_BYTES) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (cmd_ready) begin
          state_d   = ST_WAIT;
          tmo_cnt_d = 32'd0;
        end
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (cmd_done) begin
          state_d = ST_FINISH;
          if (cmd_status == 16'd0) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_cnt_d == TIMEOUT_CYCLES - 32'd1) begin
          // Host never answered; give up so the core is not stuck busy.
          state_d = ST_FINISH;
          err_d   = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and command-parameter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      slot_q    <= 16'd0;
      offset_q  <= 32'd0;
      length_q  <= 32'd0;
      tmo_cnt_q <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      offset_q  <= offset_d;
      length_q  <= length_d;
      tmo_cnt_q <= tmo_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Staging buffer write port; only open while idle so a transfer sees a
  // frozen snapshot.
  always_ff @(posedge clk) begin
    if (buf_wr && (state_q == ST_IDLE)) begin
      mem[buf_addr] <= buf_data;
    end
  end

  // Bridge read port: registered, held until the next read strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_q <= 32'd0;
    end else if (bridge_rd) begin
      rd_data_q <= rd_hit ? mem[rd_idx] : 32'd0;
    end
  end

endmodule

// File: tb/tb_dataslot_save_writer.sv
// Bench for dataslot_save_writer: directed scenarios with literal expectations
// followed by a randomized phase, all checked every cycle against a
// transaction-level reference model.
module tb_dataslot_save_writer;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 32;
  localparam int          TMO   = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        buf_wr = 1'b0;
  logic [4:0]  buf_addr = '0;
  logic [31:0] buf_data = '0;
  logic        buf_wr_dropped;
  logic        save_req = 1'b0;
  logic [15:0] save_slot_id = '0;
  logic [31:0] save_offset = '0;
  logic [31:0] save_length = '0;
  logic        busy, save_done, save_error, cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [15:0] cmd_slot_id;
  logic [31:0] cmd_offset, cmd_bridge_addr, cmd_length;
  logic        cmd_done = 1'b0;
  logic [15:0] cmd_status = '0;
  logic        bridge_rd = 1'b0;
  logic [31:0] bridge_addr = '0;
  logic [31:0] bridge_rd_data;

  always #5 clk = ~clk;

  dataslot_save_writer #(
    .BRIDGE_BASE   (BASE),
    .DEPTH_WORDS   (DEPTH),
    .TIMEOUT_CYCLES(32'(TMO))
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .buf_wr         (buf_wr),
    .buf_addr       (buf_addr),
    .buf_data       (buf_data),
    .buf_wr_dropped (buf_wr_dropped),
    .save_req       (save_req),
    .save_slot_id   (save_slot_id),
    .save_offset    (save_offset),
    .save_length    (save_length),
    .busy           (busy),
    .save_done      (save_done),
    .save_error     (save_error),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_slot_id    (cmd_slot_id),
    .cmd_offset     (cmd_offset),
    .cmd_bridge_addr(cmd_bridge_addr),
    .cmd_length     (cmd_length),
    .cmd_done       (cmd_done),
    .cmd_status     (cmd_status),
    .bridge_rd      (bridge_rd),
    .bridge_addr    (bridge_addr),
    .bridge_rd_data (bridge_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: a save is a transaction with an accept time, a handshake
  // time and a completion time; outputs follow from those timestamps.
  logic [31:0] mbuf [DEPTH];
  bit          m_active = 1'b0;
  bit          m_acc = 1'b0;
  int          m_hs = 0;
  int          m_end = -1;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_rd = '0;
  logic [15:0] m_slot = '0;
  logic [31:0] m_off = '0;
  logic [31:0] m_len = '0;

  // Advance the model by the cycle that ends at this edge.
  always @(posedge clk) begin
    logic [31:0] roff;
    bit nd, ne;
    nd = 1'b0;
    ne = 1'b0;
    if (!reset_n) begin
      m_active = 1'b0;
      m_acc    = 1'b0;
      m_end    = -1;
      m_rd     = '0;
      m_slot   = '0;
      m_off    = '0;
      m_len    = '0;
    end else begin
      if (bridge_rd) begin
        roff = bridge_addr - BASE;
        m_rd = (roff < 32'(4 * DEPTH)) ? mbuf[int'(roff >> 2)] : 32'd0;
      end
      if (m_active) begin
        if (cyc == m_end) begin
          m_active = 1'b0;
        end else if (!m_acc) begin
          if (cmd_ready) begin
            m_acc = 1'b1;
            m_hs  = cyc;
          end
        end else if (m_end < 0 && (cmd_done || cyc == m_hs + TMO - 1)) begin
          m_end = cyc + 1;
          if (cmd_done && cmd_status == 16'd0) nd = 1'b1;
          else ne = 1'b1;
        end
      end else begin
        if (buf_wr) mbuf[buf_addr] = buf_data;
        if (save_req) begin
          m_slot = save_slot_id;
          m_off  = save_offset;
          m_len  = save_length;
          if (save_length == 0) nd = 1'b1;
          else if (save_length > 32'(4 * DEPTH)) ne = 1'b1;
          else begin
            m_active = 1'b1;
            m_acc    = 1'b0;
            m_end    = -1;
          end
        end
      end
    end
    m_done = nd;
    m_err  = ne;
    chk_en = 1'b1;
    cyc++;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_active);
      chk("cmd_valid", cmd_valid, m_active && !m_acc);
      chk("save_done", save_done, m_done);
      chk("save_error", save_error, m_err);
      chk("buf_wr_dropped", buf_wr_dropped, buf_wr && m_active);
      chk("bridge_rd_data", bridge_rd_data, m_rd);
      chk("cmd_slot_id", cmd_slot_id, m_slot);
      chk("cmd_offset", cmd_offset, m_off);
      chk("cmd_length", cmd_length, m_len);
      chk("cmd_bridge_addr", cmd_bridge_addr, BASE);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    buf_wr = 1'b0; save_req = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0; bridge_rd = 1'b0;
  endtask

  task automatic do_save(input logic [15:0] s, input logic [31:0] o, input logic [31:0] l);
    save_req = 1'b1; save_slot_id = s; save_offset = o; save_length = l;
    tick();
    save_req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string nm);
    bridge_rd = 1'b1; bridge_addr = a;
    tick();
    bridge_rd = 1'b0;
    chk(nm, bridge_rd_data, expv);
  endtask

  initial begin
    int hs;
    int n;
    int r;
    clr();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_rd_data", bridge_rd_data, 0);
    chk("rst_bridge_addr", cmd_bridge_addr, 32'h1000_0000);
    chk("rst_cmd_length", cmd_length, 0);
    reset_n = 1'b1;
    tick();

    // Fill the buffer; words 0 and 1 carry the known save payload.
    for (int i = 0; i < DEPTH; i++) begin
      buf_wr = 1'b1; buf_addr = 5'(i);
      buf_data = (i == 0) ? 32'hDEAD_BEEF : (i == 1) ? 32'h0123_4567 : $urandom;
      tick();
    end
    buf_wr = 1'b0;

    // Save 8 bytes to slot 3.
    do_save(16'd3, 32'd0, 32'd8);
    chk("s8_busy", busy, 1);
    chk("s8_valid", cmd_valid, 1);
    chk("s8_slot", cmd_slot_id, 3);
    chk("s8_off", cmd_offset, 0);
    chk("s8_baddr", cmd_bridge_addr, 32'h1000_0000);
    chk("s8_len", cmd_length, 8);
    tick();
    tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("s8_valid_drop", cmd_valid, 0);
    rd(BASE, 32'hDEAD_BEEF, "s8_rd_w0");
    rd(BASE + 32'd4, 32'h0123_4567, "s8_rd_w1");
    buf_wr = 1'b1; buf_addr = 5'd0; buf_data = 32'h0;
    #1;
    chk("frozen_dropped", buf_wr_dropped, 1);
    tick();
    buf_wr = 1'b0;
    rd(BASE, 32'hDEAD_BEEF, "frozen_rd_w0");
    rd(BASE + 32'd6, 32'h0123_4567, "rd_lsb_ignored");
    cmd_done = 1'b1; cmd_status = 16'd0;
    tick();
    cmd_done = 1'b0;
    chk("s8_done", save_done, 1);
    chk("s8_no_err", save_error, 0);
    tick();
    chk("s8_done_once", save_done, 0);
    chk("s8_idle", busy, 0);

    // Host reports failure status.
    do_save(16'd5, 32'd16, 32'd16);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    cmd_done = 1'b1; cmd_status = 16'h0002;
    tick();
    cmd_done = 1'b0; cmd_status = 16'd0;
    chk("stat_err", save_error, 1);
    chk("stat_no_done", save_done, 0);
    tick();
    chk("stat_err_once", save_error, 0);
    chk("stat_idle", busy, 0);

    // Host never completes: timeout.
    do_save(16'd7, 32'd0, 32'd128);
    cmd_ready = 1'b1;
    hs = cyc;
    tick();
    cmd_ready = 1'b0;
    n = 0;
    while (save_error !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("tmo_delta", 32'(cyc - hs), 32'd100);
    tick();
    chk("tmo_idle", busy, 0);

    // Boundary lengths.
    do_save(16'd1, 32'd0, 32'd0);
    chk("len0_done", save_done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", cmd_valid, 0);
    do_save(16'd1, 32'd0, 32'd132);
    chk("big_err", save_error, 1);
    chk("big_busy", busy, 0);
    tick();
    rd(BASE + 32'd128, 32'd0, "rd_past_end");
    rd(BASE - 32'd4, 32'd0, "rd_below_base");

    // Reset while the request is pending.
    do_save(16'd2, 32'd4, 32'd4);
    chk("rq_valid", cmd_valid, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rq_valid_drop", cmd_valid, 0);
    chk("rq_busy", busy, 0);
    chk("rq_no_done", save_done, 0);
    do_save(16'd2, 32'd4, 32'd4);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done = 1'b1; cmd_status = 16'd0;
    tick();
    cmd_done = 1'b0;
    chk("rq_resave_done", save_done, 1);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset_n  = ($urandom_range(0, 199) != 0);
      buf_wr   = reset_n && ($urandom_range(0, 3) == 0);
      buf_addr = 5'($urandom_range(0, DEPTH - 1));
      buf_data = $urandom;
      save_req = ($urandom_range(0, 11) == 0);
      save_slot_id = 16'($urandom);
      save_offset  = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) save_length = 32'd0;
      else if (r == 1) save_length = 32'(4 * DEPTH + $urandom_range(1, 64));
      else save_length = 32'($urandom_range(1, 4 * DEPTH));
      cmd_ready  = ($urandom_range(0, 2) == 0);
      cmd_done   = ($urandom_range(0, 69) == 0);
      cmd_status = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
      bridge_rd  = $urandom_range(0, 1) == 1;
      bridge_addr = BASE - 32'd8 + 32'($urandom_range(0, 4 * DEPTH + 16));
      tick();
    end
    clr();
    reset_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
